// File: rtl/axis_eth_fcs_check_64.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : axis_eth_fcs_check_64
// Purpose  : 64-bit AXI4-Stream Ethernet FCS checker; strips the FCS and flags bad frames.
//            Optional frame counters enabled by AXIS_ETH_FCS_CHECK_STATS_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
module axis_eth_fcs_check_64 #(
  parameter int STAT_COUNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        status_error_bad_fcs
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
  ,
  output logic [STAT_COUNT_WIDTH-1:0] stat_good_count,
  output logic [STAT_COUNT_WIDTH-1:0] stat_bad_count
`endif
);

  localparam logic [31:0] c_crc_init    = 32'hFFFF_FFFF;
  localparam logic [31:0] c_crc_residue = 32'hDEBB_20E3;
  localparam logic [31:0] c_crc_poly    = 32'hEDB8_8320;

  // One byte through the reflected Galois LFSR (polynomial 0x04C11DB7).
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ b[i]) ? c_crc_poly : 32'h0);
    end
    return c;
  endfunction

  logic [31:0] crc_q, crc_d;

  logic        h_valid_q, h_valid_d;
  logic [63:0] h_data_q,  h_data_d;
  logic [7:0]  h_keep_q,  h_keep_d;
  logic        h_last_q,  h_last_d;
  logic        h_user_q,  h_user_d;

  logic        o_valid_q, o_valid_d;
  logic [63:0] o_data_q,  o_data_d;
  logic [7:0]  o_keep_q,  o_keep_d;
  logic        o_last_q,  o_last_d;
  logic        o_user_q,  o_user_d;

  logic        bad_fcs_q, bad_fcs_d;

  logic        o_free;
  logic        s_ready;
  logic        accept;
  logic [31:0] crc_by_n [0:8];
  logic [3:0]  last_n;
  logic        keep_ok;
  logic        crc_bad;
  logic        short_last;
  logic        runt;

  assign o_free  = !o_valid_q || m_axis_tready;
  assign s_ready = o_free && !(h_valid_q && h_last_q);
  assign accept  = s_axis_tvalid && s_ready;

  // crc_by_n[k] is the CRC state after the first k bytes of the current beat.
  always_comb begin
    logic [31:0] c;
    c = crc_q;
    crc_by_n[0] = crc_q;
    for (int i = 0; i < 8; i++) begin
      c = crc_byte(c, s_axis_tdata[8*i +: 8]);
      crc_by_n[i+1] = c;
    end
  end

  always_comb begin
    last_n  = 4'd8;
    keep_ok = 1'b1;
    case (s_axis_tkeep)
      8'h01:   last_n = 4'd1;
      8'h03:   last_n = 4'd2;
      8'h07:   last_n = 4'd3;
      8'h0F:   last_n = 4'd4;
      8'h1F:   last_n = 4'd5;
      8'h3F:   last_n = 4'd6;
      8'h7F:   last_n = 4'd7;
      8'hFF:   last_n = 4'd8;
      default: keep_ok = 1'b0;
    endcase
  end

  assign crc_bad    = !keep_ok || (crc_by_n[last_n] != c_crc_residue);
  assign short_last = (last_n <= 4'd4);
  assign runt       = short_last && !h_valid_q;

  always_comb begin
    crc_d     = crc_q;
    h_valid_d = h_valid_q;
    h_data_d  = h_data_q;
    h_keep_d  = h_keep_q;
    h_last_d  = h_last_q;
    h_user_d  = h_user_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_keep_d  = o_keep_q;
    o_last_d  = o_last_q;
    o_user_d  = o_user_q;
    bad_fcs_d = 1'b0;

    if (o_free) begin
      o_valid_d = 1'b0;
    end

    if (accept) begin
      if (!s_axis_tlast) begin
        crc_d = crc_by_n[8];
        if (h_valid_q) begin
          o_valid_d = 1'b1;
          o_data_d  = h_data_q;
          o_keep_d  = 8'hFF;
          o_last_d  = 1'b0;
          o_user_d  = 1'b0;
        end
        h_valid_d = 1'b1;
        h_data_d  = s_axis_tdata;
        h_keep_d  = 8'hFF;
        h_last_d  = 1'b0;
        h_user_d  = 1'b0;
      end else begin
        crc_d     = c_crc_init;
        bad_fcs_d = crc_bad || runt;
        if (!short_last) begin
          if (h_valid_q) begin
            o_valid_d = 1'b1;
            o_data_d  = h_data_q;
            o_keep_d  = 8'hFF;
            o_last_d  = 1'b0;
            o_user_d  = 1'b0;
          end
          // Last beat still carries payload: it waits in H with the FCS bytes masked off.
          h_valid_d = 1'b1;
          h_data_d  = s_axis_tdata;
          h_keep_d  = 8'hFF >> (4'd12 - last_n);
          h_last_d  = 1'b1;
          h_user_d  = s_axis_tuser || crc_bad;
        end else if (h_valid_q) begin
          o_valid_d = 1'b1;
          o_data_d  = h_data_q;
          o_keep_d  = 8'hFF >> (4'd4 - last_n);
          o_last_d  = 1'b1;
          o_user_d  = s_axis_tuser || crc_bad;
          h_valid_d = 1'b0;
          h_last_d  = 1'b0;
        end else begin
          o_valid_d = 1'b1;
          o_data_d  = 64'h0;
          o_keep_d  = 8'h01;
          o_last_d  = 1'b1;
          o_user_d  = 1'b1;
        end
      end
    end else if (h_valid_q && h_last_q && o_free) begin
      o_valid_d = 1'b1;
      o_data_d  = h_data_q;
      o_keep_d  = h_keep_q;
      o_last_d  = 1'b1;
      o_user_d  = h_user_q;
      h_valid_d = 1'b0;
      h_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q     <= c_crc_init;
      h_valid_q <= 1'b0;
      h_data_q  <= 64'h0;
      h_keep_q  <= 8'h0;
      h_last_q  <= 1'b0;
      h_user_q  <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= 64'h0;
      o_keep_q  <= 8'h0;
      o_last_q  <= 1'b0;
      o_user_q  <= 1'b0;
      bad_fcs_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      h_keep_q  <= h_keep_d;
      h_last_q  <= h_last_d;
      h_user_q  <= h_user_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_keep_q  <= o_keep_d;
      o_last_q  <= o_last_d;
      o_user_q  <= o_user_d;
      bad_fcs_q <= bad_fcs_d;
    end
  end

  assign s_axis_tready        = s_ready;
  assign m_axis_tdata         = o_data_q;
  assign m_axis_tkeep         = o_keep_q;
  assign m_axis_tvalid        = o_valid_q;
  assign m_axis_tlast         = o_last_q;
  assign m_axis_tuser         = o_user_q;
  assign status_error_bad_fcs = bad_fcs_q;

`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
  logic                        frame_done;
  logic                        frame_bad;
  logic [STAT_COUNT_WIDTH-1:0] good_cnt_q;
  logic [STAT_COUNT_WIDTH-1:0] bad_cnt_q;

  assign frame_done = accept && s_axis_tlast;
  assign frame_bad  = crc_bad || runt || s_axis_tuser;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else if (frame_done) begin
      if (frame_bad) begin
        if (bad_cnt_q != '1) bad_cnt_q <= bad_cnt_q + 1'b1;
      end else begin
        if (good_cnt_q != '1) good_cnt_q <= good_cnt_q + 1'b1;
      end
    end
  end

  assign stat_good_count = good_cnt_q;
  assign stat_bad_count  = bad_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_eth_fcs_check_64.sv
`default_nettype none
// Scoreboard bench for axis_eth_fcs_check_64: directed frames, expected beats queued at issue.
module tb_axis_eth_fcs_check_64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        status_error_bad_fcs;
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
  logic [31:0] stat_good_count;
  logic [31:0] stat_bad_count;
`endif

  always #5 clk = ~clk;

  axis_eth_fcs_check_64 #(.STAT_COUNT_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tuser         (s_axis_tuser),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tkeep         (m_axis_tkeep),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tuser         (m_axis_tuser),
    .status_error_bad_fcs (status_error_bad_fcs)
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
    ,
    .stat_good_count      (stat_good_count),
    .stat_bad_count       (stat_bad_count)
`endif
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          tests = 0;
  int          fails = 0;
  int          pulse_cnt = 0;
  int          exp_pulses = 0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [74:0] prev_snap = '0;
  logic [63:0] mask;

  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (status_error_bad_fcs) pulse_cnt++;
      if (prev_stall) begin
        tests++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} != prev_snap) begin
          fails++;
          $display("FAIL axi_stable: got %h required %h", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, prev_snap);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got data %h keep %h last %b user %b, none required", m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser);
        end else begin
          mon_e = exp_q.pop_front();
          for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{mon_e.k[b]}};
          if (((m_axis_tdata & mask) != (mon_e.d & mask)) || (m_axis_tkeep != mon_e.k) ||
              (m_axis_tlast != mon_e.l) || (m_axis_tuser != mon_e.u)) begin
            fails++;
            $display("FAIL out_beat: got data %h keep %h last %b user %b, required data %h keep %h last %b user %b",
                     m_axis_tdata & mask, m_axis_tkeep, m_axis_tlast, m_axis_tuser, mon_e.d & mask, mon_e.k, mon_e.l, mon_e.u);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_snap  = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l, input bit u);
    bit ok;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got tready 0 for 1000 cycles, required 1");
    end
  endtask

  // Payload byte i = i*13+seed; a correct FCS is appended, then one bit may be flipped.
  task automatic send_frame(input int plen, input int seed, input int flip, input bit tu);
    byte unsigned f[$];
    logic [31:0]  crc;
    logic [63:0]  d;
    beat_t        e;
    int           total, nb, cnt;
    f.delete();
    for (int i = 0; i < plen; i++) f.push_back(8'(i * 13 + seed));
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < plen; i++) begin
      crc = crc ^ {24'h0, f[i]};
      for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) f.push_back(crc[8*i +: 8]);
    if (flip >= 0) begin
      f[flip] = f[flip] ^ 8'h01;
      exp_pulses++;
    end
    nb = (plen + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      cnt = (plen - 8*b > 8) ? 8 : plen - 8*b;
      d = '0;
      for (int i = 0; i < cnt; i++) d[8*i +: 8] = f[8*b + i];
      e.d = d;
      e.k = 8'((1 << cnt) - 1);
      e.l = (b == nb - 1);
      e.u = (b == nb - 1) && ((flip >= 0) || tu);
      exp_q.push_back(e);
    end
    total = plen + 4;
    nb = (total + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      cnt = (total - 8*b > 8) ? 8 : total - 8*b;
      d = '0;
      for (int i = 0; i < cnt; i++) d[8*i +: 8] = f[8*b + i];
      send_beat(d, 8'((1 << cnt) - 1), b == nb - 1, (b == nb - 1) ? tu : 1'b0);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_section(input string name);
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_bad_fcs_pulses"}, 64'(pulse_cnt), 64'(exp_pulses));
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish within 30000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_bad_fcs", 64'(status_error_bad_fcs), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_tready", 64'(s_axis_tready), 64'd1);

    send_frame(60, 1, -1, 1'b0);     // 64 bytes, last keep FF -> out keep 0F
    check_section("frame64");
    send_frame(62, 2, -1, 1'b0);     // 66 bytes, last keep 03 -> out keep 3F
    check_section("frame66");
    send_frame(60, 1, 10, 1'b0);     // byte 10 bit 0 flipped
    check_section("bad_fcs");
    send_frame(60, 3, -1, 1'b1);     // upstream error only
    check_section("upstream_err");
    send_frame(4, 4, -1, 1'b0);      // single 8-byte beat -> 4 bytes out
    check_section("short8");

    exp_q.push_back('{d: 64'h0, k: 8'h01, l: 1'b1, u: 1'b1});
    exp_pulses++;
    send_beat(64'h0000_0000_1234_5678, 8'h0F, 1'b1, 1'b0);
    s_axis_tvalid = 1'b0;
    check_section("runt");

    rand_ready = 1'b1;
    send_frame(64, 5, -1, 1'b0);     // 68 bytes, last keep 0F -> 8 full beats out
    send_frame(64, 6, -1, 1'b0);
    send_frame(64, 7, -1, 1'b0);
    check_section("b2b_random_ready");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Partial frame: the first beat leaves O before reset, the second is discarded.
    exp_q.push_back('{d: 64'h1111_2222_3333_4444, k: 8'hFF, l: 1'b0, u: 1'b0});
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tdata", m_axis_tdata, 64'd0);
    chk("midrst_tkeep", 64'(m_axis_tkeep), 64'd0);
    chk("midrst_exp_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(60, 8, -1, 1'b0);
    check_section("after_reset");
`ifdef AXIS_ETH_FCS_CHECK_STATS_EN
    chk("stat_good", 64'(stat_good_count), 64'd1);
    chk("stat_bad", 64'(stat_bad_count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_eth_fcs_check_64.md
Name: axis_eth_fcs_check_64

Overview:
Ethernet FCS checker for a 64-bit AXI4-Stream datapath, used on the receive side of the MAC. It accepts frames that still carry the 4-byte FCS, runs the CRC-32 over every byte including the FCS, and strips the FCS from the output stream. It flags bad frames by setting m_axis_tuser on the last output beat and pulsing a status output. The CRC uses ve_lfsr instances with LFSR_WIDTH 32, POLY 32'h4c11db7, GALOIS, REVERSE 1, and DATA_WIDTH 8..64 in 8-bit steps.

Parameters:
STAT_COUNT_WIDTH, 32, width of the optional good/bad frame counters.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
s_axis_tdata  input  64  frame data with FCS; byte 0 in [7:0]
s_axis_tkeep  input  8  byte enables; must be 8'hFF on non-last beats
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
s_axis_tlast  input  1  last beat of frame
s_axis_tuser  input  1  upstream error; sampled on the tlast beat only
m_axis_tdata  output  64  frame data, FCS stripped
m_axis_tkeep  output  8  byte enables
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  last beat
m_axis_tuser  output  1  frame error; meaningful on the tlast beat only
status_error_bad_fcs  output  1  one-cycle pulse on CRC mismatch
stat_good_count  output  STAT_COUNT_WIDTH  present only with the macro
stat_bad_count  output  STAT_COUNT_WIDTH  present only with the macro

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- Reset: crc_state=32'hFFFFFFFF. Hold register H and output register O are empty. m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tkeep=0, m_axis_tdata=0, status_error_bad_fcs=0, counters=0.
- Storage:
  - H holds the most recent beat, because its final tkeep/tlast depend on the next beat. It carries a flag H_final.
  - O drives m_axis_* directly (registered outputs, no combinational s-to-m path).
- Handshakes:
  - s_axis_tready = (!O_valid || m_axis_tready) && !(H_valid && H_final).
  - O loads whenever it is empty or being consumed and a beat is ready to move.
  - AXI rules hold: m_axis_* is stable while tvalid && !tready.
- CRC:
  - Non-last accepted beat: crc_state <= 64-bit LFSR result.
  - Last beat with n contiguous bytes (tkeep = 2^n-1): use the n*8-bit result. The frame is good iff that result == 32'hDEBB20E3.
  - Any non-contiguous last tkeep is treated as an FCS error.
  - crc_state returns to 32'hFFFFFFFF on the last beat.
- Accepted non-last beat: if H is valid, H moves to O as non-last with tkeep 8'hFF; then H <= input.
- Accepted last beat, n>4:
  - H (if valid) moves to O as non-last.
  - H <= input with tkeep = 2^(n-4)-1, tlast=1, tuser = s_axis_tuser | bad, H_final=1.
  - H then drains to O on the next O-free cycle without further input.
- Accepted last beat, n<=4: the input beat is dropped.
  - H moves to O with tlast=1, tkeep = 8'hFF >> (4-n), tuser = s_axis_tuser | bad.
  - n=4 gives 8'hFF; n=1 gives 8'h1F.
- Runt frame (single-beat frame with n<=4, H empty): O <= tdata 0, tkeep 8'h01, tlast=1, tuser=1. status_error_bad_fcs pulses.
- status_error_bad_fcs pulses in the cycle after the last beat is accepted when the CRC mismatches, independent of s_axis_tuser.
- Latency: an output beat appears at least 1 cycle after its successor beat is accepted. A final beat with n>4 leaves 1 cycle after entering H.
- Throughput: 1 beat/cycle under continuous ready, except one bubble after a last beat with n>4.
- Reset mid-frame: all state is cleared immediately. The partial frame is discarded and downstream sees no tlast for it. The next frame is checked from a fresh CRC.

Optional Feature:
Macro AXIS_ETH_FCS_CHECK_STATS_EN.
- Defined: stat_good_count / stat_bad_count exist and increment by 1 per completed frame. A frame counts as bad if the FCS mismatches or s_axis_tuser=1 on its last beat. Counters saturate at all-ones and clear on rst.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- 64-byte frame (60 payload + valid FCS), 8 beats, last tkeep 8'hFF, ready held 1 -> 8 output beats; last tkeep 8'h0F, tuser 0; no bad_fcs pulse; payload bytes match.
- 66-byte frame, last input tkeep 8'h03 -> 8 output beats; last tkeep 8'h3F, tlast on output beat 8; tuser 0.
- Same 64-byte frame with bit 0 of byte 10 flipped -> output last tuser 1; status_error_bad_fcs high for exactly 1 cycle.
- Valid frame with s_axis_tuser=1 on last beat -> output tuser 1; no bad_fcs pulse.
- Back-to-back valid 68-byte frames (last tkeep 8'h0F) with m_axis_tready randomly 50% -> byte-exact output, 64 bytes per frame, no beats lost or duplicated, AXI stability held.
- rst asserted after beat 3 of a frame, then a valid 64-byte frame -> outputs drop to reset values immediately; second frame passes with tuser 0. With the macro defined, stat_good_count=1 and stat_bad_count=0.
